// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder.
// Contents: FSM state enum, latency counter width, captured-request payload,
// and the address range-check helper.
package data_mem_responder_pkg;

  localparam int unsigned CNT_BITS  = 4;
  localparam int unsigned DATA_BITS = 32;
  localparam int unsigned BE_BITS   = DATA_BITS / 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } dmem_state_t;

  // Request fields held for the duration of a transaction.
  typedef struct packed {
    logic [DATA_BITS-1:0] wdata;
    logic [BE_BITS-1:0]   be;
    logic                 is_write;
    logic                 drop;     // out-of-range: no array access
  } dmem_req_t;

  // True when any byte-address bit above the word array is set.
  function automatic logic addr_out_of_range(input logic [31:0] addr,
                                             input int unsigned addr_bits);
    return (addr >> (addr_bits + 2)) != 32'd0;
  endfunction

endpackage

// File: rtl/data_mem_responder_array.sv
// Word storage for the data-memory responder.
// Ports:
//   clk, rst              clock; rst clears only the read-data register
//   rd_en, rd_addr        synchronous read; rd_data is 0 on cycles without rd_en
//   rd_data               registered read word
//   wr_en, wr_addr,
//   wr_data, wr_be        byte-enabled synchronous write
module dmem_array
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [BE_BITS-1:0]   wr_be
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_BITS;

  logic [DATA_BITS-1:0] mem [DEPTH];

  // Byte-lane write; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < int'(BE_BITS); i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Read register doubles as the zero-when-idle output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency responder for the CPU data-memory port.
// Ports:
//   clk, rst                 clock, async active-high reset
//   data_mem_read/write      request strobes, held until data_mem_resp
//   data_mem_address         byte address (bits [1:0] ignored)
//   data_mem_wdata           lane-aligned write data
//   data_mem_byte_enable     write lane enables
//   data_mem_rdata           read data, zero unless data_mem_resp
//   data_mem_resp            one-cycle completion pulse
//   err                      sticky error (out of range, or read+write)
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_mem_read,
  input  logic                 data_mem_write,
  input  logic [31:0]          data_mem_address,
  input  logic [DATA_BITS-1:0] data_mem_wdata,
  input  logic [BE_BITS-1:0]   data_mem_byte_enable,
  output logic [DATA_BITS-1:0] data_mem_rdata,
  output logic                 data_mem_resp,
  output logic                 err
);

  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  dmem_state_t          state_q, state_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  dmem_req_t            req_q, req_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic                 err_q, err_d;
  logic                 resp_q, resp_d;

  dmem_req_t            req_in_c;
  logic [ADDR_BITS-1:0] idx_in_c;
  logic                 bad_in_c;
  logic                 rd_en_c;
  logic [ADDR_BITS-1:0] rd_idx_c;
  logic                 wr_en_c;
  logic                 unused_addr_lsb;

  assign unused_addr_lsb = ^data_mem_address[1:0];

  // Decode the live request; read+write together is performed as a write.
  always_comb begin
    req_in_c.wdata    = data_mem_wdata;
    req_in_c.be       = data_mem_byte_enable;
    req_in_c.is_write = data_mem_write;
    req_in_c.drop     = addr_out_of_range(data_mem_address, ADDR_BITS);
    idx_in_c          = data_mem_address[ADDR_BITS+1:2];
    bad_in_c          = req_in_c.drop | (data_mem_read & data_mem_write);
  end

  // Next-state, capture and array-control logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    idx_d    = idx_q;
    err_d    = err_q;
    resp_d   = 1'b0;
    rd_en_c  = 1'b0;
    rd_idx_c = idx_q;
    wr_en_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (data_mem_read || data_mem_write) begin
          req_d = req_in_c;
          idx_d = idx_in_c;
          err_d = err_q | bad_in_c;
          if (LATENCY == 1) begin
            // Single-cycle latency reads straight from the live address.
            state_d  = RESP;
            resp_d   = 1'b1;
            rd_en_c  = !req_in_c.is_write && !req_in_c.drop;
            rd_idx_c = idx_in_c;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          // Array read lands in rd_data as RESP begins.
          state_d = RESP;
          resp_d  = 1'b1;
          rd_en_c = !req_q.is_write && !req_q.drop;
        end
      end
      RESP: begin
        state_d = IDLE;
        wr_en_c = req_q.is_write && !req_q.drop;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      resp_q  <= resp_d;
    end
  end

  dmem_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en_c),
    .rd_addr (rd_idx_c),
    .rd_data (data_mem_rdata),
    .wr_en   (wr_en_c),
    .wr_addr (idx_q),
    .wr_data (req_q.wdata),
    .wr_be   (req_q.be)
  );

  assign data_mem_resp = resp_q;
  assign err           = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a word-array model.
module tb_data_mem_responder;

  localparam int unsigned AB    = 10;
  localparam int          LAT   = 2;
  localparam int          WORDS = 1 << AB;

  logic        clk;
  logic        rst;
  logic        data_mem_read;
  logic        data_mem_write;
  logic [31:0] data_mem_address;
  logic [31:0] data_mem_wdata;
  logic [3:0]  data_mem_byte_enable;
  logic [31:0] data_mem_rdata;
  logic        data_mem_resp;
  logic        err;

  data_mem_responder #(
    .ADDR_BITS (AB),
    .LATENCY   (LAT)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .data_mem_read        (data_mem_read),
    .data_mem_write       (data_mem_write),
    .data_mem_address     (data_mem_address),
    .data_mem_wdata       (data_mem_wdata),
    .data_mem_byte_enable (data_mem_byte_enable),
    .data_mem_rdata       (data_mem_rdata),
    .data_mem_resp        (data_mem_resp),
    .err                  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain word array, known-word map, sticky error bit.
  logic [31:0] mmem  [WORDS];
  bit          known [WORDS];
  bit          err_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  task automatic idle_inputs();
    data_mem_read        = 1'b0;
    data_mem_write       = 1'b0;
    data_mem_address     = 32'h0;
    data_mem_wdata       = 32'h0;
    data_mem_byte_enable = 4'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    err_m = 1'b0;
    @(negedge clk);
  endtask

  // One transaction starting at a negedge with the DUT idle; ends at a negedge, idle.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] be, input bit mid_change,
                     output logic [31:0] got);
    int  resp_cyc, pulses, leak, idx;
    bit  bad;
    data_mem_read        = rd;
    data_mem_write       = wr;
    data_mem_address     = addr;
    data_mem_wdata       = wd;
    data_mem_byte_enable = be;
    resp_cyc = -1; pulses = 0; leak = 0; got = 32'h0;
    for (int c = 1; c <= LAT + 2; c++) begin
      @(negedge clk);
      if (mid_change && c == 1 && !data_mem_resp) begin
        data_mem_read        = 1'b0;
        data_mem_write       = 1'b0;
        data_mem_address     = $urandom;
        data_mem_wdata       = $urandom;
        data_mem_byte_enable = 4'hF;
      end
      if (data_mem_resp) begin
        pulses++;
        resp_cyc = c;
        got = data_mem_rdata;
        idle_inputs();
      end else if (data_mem_rdata !== 32'h0) begin
        leak++;
      end
    end
    idle_inputs();
    check("resp_cycle", 32'(resp_cyc), 32'(LAT));
    check("resp_pulses", 32'(pulses), 32'd1);
    check("rdata_zero_idle", 32'(leak), 32'd0);
    bad = addr >= 32'(4 * WORDS);
    idx = int'(addr / 4) % WORDS;
    err_m = err_m | bad | (rd & wr);
    if (wr) begin
      if (!bad && known[idx]) mmem[idx] = merge(mmem[idx], wd, be);
      else if (!bad && be == 4'hF) begin mmem[idx] = wd; known[idx] = 1'b1; end
      else if (!bad && be != 4'h0) known[idx] = 1'b0;
    end else if (bad) begin
      check("rdata_oor", got, 32'h0);
    end else if (known[idx]) begin
      check("rdata_model", got, mmem[idx]);
    end
    check("err_model", {31'h0, err}, {31'h0, err_m});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    int          first, second, pulses;
    bit          rd, wr;
    logic [31:0] addr;
    int          op;

    for (int i = 0; i < WORDS; i++) known[i] = 1'b0;
    err_m = 1'b0;
    rst   = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_resp", {31'h0, data_mem_resp}, 32'h0);
    check("reset_rdata", data_mem_rdata, 32'h0);
    check("reset_err", {31'h0, err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Full write then read.
    txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0, got);
    txn(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, got);
    check("rd_deadbeef", got, 32'hDEADBEEF);

    // Partial lane writes.
    txn(1'b0, 1'b1, 32'h10, 32'h0000AB00, 4'b0010, 1'b0, got);
    txn(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, got);
    check("rd_lane1", got, 32'hDEADABEF);
    txn(1'b0, 1'b1, 32'h10, 32'h12340000, 4'b1100, 1'b0, got);
    txn(1'b1, 1'b0, 32'h13, 32'h0, 4'h0, 1'b0, got);
    check("rd_lane23", got, 32'h1234ABEF);

    // Zero byte enable leaves the word alone.
    txn(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b0, got);
    txn(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, got);
    check("rd_be0", got, 32'h1234ABEF);
    check("err_clean", {31'h0, err}, 32'h0);

    // Out-of-range read, then sticky error.
    txn(1'b1, 1'b0, 32'h00001000, 32'h0, 4'h0, 1'b0, got);
    check("oor_rdata", got, 32'h0);
    check("oor_err", {31'h0, err}, 32'h1);
    txn(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, got);
    check("err_sticky", {31'h0, err}, 32'h1);

    // Read and write together act as a write.
    txn(1'b1, 1'b1, 32'h20, 32'h55AA55AA, 4'b1111, 1'b0, got);
    txn(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, got);
    check("rdwr_data", got, 32'h55AA55AA);

    // Inputs changed and dropped during BUSY are ignored.
    txn(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, got);
    check("busy_ignore", got, 32'h1234ABEF);

    // Request held across resp: second response LAT+1 cycles after the first.
    data_mem_read    = 1'b1;
    data_mem_address = 32'h20;
    first = -1; second = -1; pulses = 0;
    for (int c = 1; c <= 2 * LAT + 3; c++) begin
      @(negedge clk);
      if (data_mem_resp) begin
        pulses++;
        if (pulses == 1) first = c;
        else second = c;
        check("hold_rdata", data_mem_rdata, 32'h55AA55AA);
        if (pulses == 2) idle_inputs();
      end
    end
    idle_inputs();
    check("hold_first", 32'(first), 32'(LAT));
    check("hold_second", 32'(second), 32'(2 * LAT + 1));
    check("hold_pulses", 32'(pulses), 32'd2);

    // Reset during BUSY of a write discards it.
    txn(1'b0, 1'b1, 32'h30, 32'h11111111, 4'b1111, 1'b0, got);
    data_mem_write       = 1'b1;
    data_mem_address     = 32'h30;
    data_mem_wdata       = 32'h22222222;
    data_mem_byte_enable = 4'hF;
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    #1;
    pulses = 0;
    check("rst_busy_rdata", data_mem_rdata, 32'h0);
    check("rst_busy_err", {31'h0, err}, 32'h0);
    for (int c = 0; c < LAT + 2; c++) begin
      @(negedge clk);
      if (data_mem_resp) pulses++;
    end
    rst   = 1'b0;
    err_m = 1'b0;
    for (int c = 0; c < LAT + 2; c++) begin
      @(negedge clk);
      if (data_mem_resp) pulses++;
    end
    check("rst_busy_noresp", 32'(pulses), 32'd0);
    txn(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0, got);
    check("rst_busy_kept", got, 32'h11111111);

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 200; n++) begin
      op = int'($urandom_range(0, 9));
      rd = (op <= 3) || (op == 8);
      wr = (op >= 4);
      if (op == 9) wr = 1'b1;
      if (op == 9) rd = 1'b0;
      if ($urandom_range(0, 11) == 0) addr = $urandom | 32'h00001000;
      else addr = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
      txn(rd, wr, addr, $urandom, 4'($urandom_range(0, 15)), bit'($urandom_range(0, 3) == 0), got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
